// File: rtl/presort_pkg.sv
// Shared definitions for the presorter dispatch slice: chunk geometry,
// default presorter depth and the tagged buffer entry type.
package presort_pkg;

    localparam int CHUNK_ELEMS             = 16;
    localparam int PRESORT_LATENCY_DEFAULT = 10;
    localparam int DATA_WIDTH_DEFAULT      = 32;

    // Width of one chunk (16 elements) for a given element width.
    function automatic int chunk_width(input int data_width);
        return CHUNK_ELEMS * data_width;
    endfunction

    // Buffered chunk plus its end-of-stream marker, sized for the default element width.
    typedef struct packed {
        logic [CHUNK_ELEMS*DATA_WIDTH_DEFAULT-1:0] data;
        logic                                      last;
    } tagged_entry_t;

endpackage

// File: rtl/presort_obuf.sv
// Synchronous circular FIFO holding sorted chunks between the free-running
// presorter and the leaf dispatcher. Pointers carry one extra wrap bit so
// full and empty are distinguished without an occupancy counter.
module presort_obuf
    import presort_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = tagged_entry_t
) (
    input  logic   aclk,
    input  logic   aresetn,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   empty,
    output logic   full
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic   [AW:0] wr_ptr;
    logic   [AW:0] rd_ptr;

    // Pointer state; the only part of the buffer that needs clearing.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // The credit scheme upstream guarantees a free slot for every push.
    a_no_overflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(push && full && !pop));

    // The dispatcher only pops a non-empty buffer.
    a_no_underflow: assert property (@(posedge aclk) disable iff (!aresetn)
        !(pop && empty));

endmodule

// File: rtl/presort_dispatch.sv
// Presorter companion: accepts 512-bit chunks, feeds the unstallable presorter,
// re-tags its output with valid/last, buffers it under credit protection and
// deals chunks round-robin to the merger leaf FIFOs in runs of CHUNKS_PER_RUN.
// Optional build macro PRESORT_CHECK_EN adds a sticky sort_err output that
// flags any pushed chunk whose elements are not in ascending order.
module presort_dispatch
    import presort_pkg::*;
#(
    parameter int  DATA_WIDTH      = 32,
    parameter int  PRESORT_LATENCY = PRESORT_LATENCY_DEFAULT,
    parameter int  OUT_BUF_DEPTH   = 16,
    parameter int  NUM_LEAVES      = 8,
    parameter int  CHUNKS_PER_RUN  = 4,
    localparam int CHUNK_W         = chunk_width(DATA_WIDTH),
    localparam int LEAF_W          = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CHUNK_W-1:0]    s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [CHUNK_W-1:0]    ps_in_data,
    input  logic [CHUNK_W-1:0]    ps_out_data,
    output logic [CHUNK_W-1:0]    leaf_wr_data,
    output logic [NUM_LEAVES-1:0] leaf_wr_en,
    input  logic [NUM_LEAVES-1:0] leaf_full,
    output logic                  run_done,
    output logic [LEAF_W-1:0]     cur_leaf
`ifdef PRESORT_CHECK_EN
    ,
    output logic                  sort_err
`endif
);

    localparam int RES_W = $clog2(OUT_BUF_DEPTH + 1);
    localparam int CNT_W = (CHUNKS_PER_RUN > 1) ? $clog2(CHUNKS_PER_RUN) : 1;

    typedef struct packed {
        logic [CHUNK_W-1:0] data;
        logic               last;
    } chunk_entry_t;

    // Advance to the next leaf, wrapping after the highest index.
    function automatic logic [LEAF_W-1:0] next_leaf(input logic [LEAF_W-1:0] leaf);
        if (leaf == LEAF_W'(NUM_LEAVES - 1)) return '0;
        return leaf + 1'b1;
    endfunction

    logic                       rdy_en;
    logic [RES_W-1:0]           reserved;
    logic [CNT_W-1:0]           chunk_cnt;
    logic [PRESORT_LATENCY-1:0] vld_p;
    logic [PRESORT_LATENCY-1:0] last_p;

    logic                       acc;
    logic                       push;
    logic                       pop;
    logic                       run_end;
    logic                       full_cur;
    logic                       buf_empty;
    logic                       buf_full;
    chunk_entry_t               push_entry;
    chunk_entry_t               head;

    assign acc        = s_tvalid & s_tready;
    assign s_tready   = rdy_en & (reserved < RES_W'(OUT_BUF_DEPTH));
    assign ps_in_data = s_tdata;

    // Ready is withheld for the reset cycle and enabled from the first clock after release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    // Tag pipe mirroring the presorter depth: stage 0 captures the accept, the tail marks valid output.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= acc;
            last_p[0] <= s_tlast;
            for (int i = 1; i < PRESORT_LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
        end
    end

    // ---- presorter output boundary: tail tag qualifies ps_out_data ----
    assign push       = vld_p[PRESORT_LATENCY-1];
    assign push_entry = '{data: ps_out_data, last: last_p[PRESORT_LATENCY-1]};

    // Credits cover every chunk in flight or buffered, so the pipeline can never overrun the buffer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reserved <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   reserved <= reserved + 1'b1;
                2'b01:   reserved <= reserved - 1'b1;
                default: reserved <= reserved;
            endcase
        end
    end

    presort_obuf #(
        .DEPTH   (OUT_BUF_DEPTH),
        .entry_t (chunk_entry_t)
    ) u_obuf (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (buf_empty),
        .full       (buf_full)
    );

    // ---- dispatch boundary: buffer head drives the shared leaf bus ----
    // Dispatch strictly to the current leaf; a full leaf stalls everything behind it.
    always_comb begin
        full_cur   = 1'b0;
        leaf_wr_en = '0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (cur_leaf == LEAF_W'(i)) full_cur = leaf_full[i];
        end
        pop = !buf_empty && !full_cur;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            leaf_wr_en[i] = pop && (cur_leaf == LEAF_W'(i));
        end
        run_end = pop && ((chunk_cnt == CNT_W'(CHUNKS_PER_RUN - 1)) || head.last);
    end

    assign leaf_wr_data = head.data;
    assign run_done     = run_end;

    // Run bookkeeping: count chunks per run and move to the next leaf when a run closes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            chunk_cnt <= '0;
            cur_leaf  <= '0;
        end else if (run_end) begin
            chunk_cnt <= '0;
            cur_leaf  <= next_leaf(cur_leaf);
        end else if (pop) begin
            chunk_cnt <= chunk_cnt + 1'b1;
        end
    end

`ifdef PRESORT_CHECK_EN
    // True when some adjacent element pair of the chunk is descending.
    function automatic logic chunk_unsorted(input logic [CHUNK_W-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < CHUNK_ELEMS - 1; k++) begin
            if (d[k*DATA_WIDTH +: DATA_WIDTH] > d[(k+1)*DATA_WIDTH +: DATA_WIDTH]) bad = 1'b1;
        end
        return bad;
    endfunction

    // Sticky order check on every chunk entering the buffer; only reset clears it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                 sort_err <= 1'b0;
        else if (push && chunk_unsorted(ps_out_data)) sort_err <= 1'b1;
    end
`endif

endmodule

// File: doc/presort_dispatch.md
Name: presort_dispatch

Overview:
- Downstream companion of the 16-element presorter network: accepts 512-bit AXI-stream beats, forwards them to the free-running presorter (fixed latency, no stall), and re-tags the sorted result with valid/last.
- Buffers sorted chunks in a credit-protected output FIFO so the unstallable pipeline never overflows.
- Dispatches chunks round-robin, one run of CHUNKS_PER_RUN chunks per leaf, into the merger tree's leaf FIFOs.

Parameters:
- DATA_WIDTH, 32: element width; chunk = 16*DATA_WIDTH bits.
- PRESORT_LATENCY, 10: presorter pipeline depth in cycles; must equal the instantiated network's stage count.
- OUT_BUF_DEPTH, 16: output buffer entries; power of 2, >= PRESORT_LATENCY+2.
- NUM_LEAVES, 8: number of leaf FIFOs fed.
- CHUNKS_PER_RUN, 4: chunks per run before moving to the next leaf; >= 1.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_tdata  in  16*DATA_WIDTH  input chunk.
- s_tvalid  in  1  input valid.
- s_tlast  in  1  last chunk of the input stream.
- s_tready  out  1  input ready.
- ps_in_data  out  16*DATA_WIDTH  to presorter in_data; equals s_tdata.
- ps_out_data  in  16*DATA_WIDTH  from presorter out_data.
- leaf_wr_data  out  16*DATA_WIDTH  chunk to the leaf FIFOs; shared bus.
- leaf_wr_en  out  NUM_LEAVES  one-hot write strobe.
- leaf_full  in  NUM_LEAVES  leaf FIFO full flags.
- run_done  out  1  pulses with the final write of each run.
- cur_leaf  out  clog2(NUM_LEAVES)  leaf currently targeted.

Behaviour:
- Clock and reset: all state is clocked on aclk and cleared asynchronously on aresetn low. The presorter itself is not reset.
- Reset values: s_tready=0, leaf_wr_en=0, run_done=0, cur_leaf=0. Also cleared: buffer pointers, reserved counter, chunk counter, and the valid/last pipe.
- Ready after reset: rdy_en flop is 0 in reset and 1 from the first clock after release.
- Accept: acc = s_tvalid & s_tready.
- Tag pipe: {valid,last} shift register of PRESORT_LATENCY stages. Stage 0 captures {acc, s_tlast}. On tail valid, ps_out_data and the tail last bit are pushed into the buffer.
- Latency: beat accepted at edge t is pushed at edge t+PRESORT_LATENCY and is first visible on leaf_wr_data in the following cycle.
- Credit counter "reserved" (clog2(OUT_BUF_DEPTH+1) bits) counts in-flight plus buffered chunks:
  - +1 on acc, -1 on pop; both in the same cycle leaves it unchanged.
  - s_tready = rdy_en & (reserved < OUT_BUF_DEPTH).
  - Overflow is therefore impossible; a push into a full buffer is an assertion failure.
- Dispatch (combinational from registered state):
  - leaf_wr_en[cur_leaf] = !empty & !leaf_full[cur_leaf]; pop = that strobe.
  - leaf_wr_data = buffer head data.
- Run tracking:
  - chunk_cnt increments on each pop.
  - Run end = pop & (chunk_cnt==CHUNKS_PER_RUN-1 | head.last).
  - On run end: run_done=1 that cycle, chunk_cnt<=0, cur_leaf<=cur_leaf+1 (wraps NUM_LEAVES-1 -> 0).
  - A short last run ends early; the next stream starts on the next leaf.
- Boundaries:
  - leaf_full held high stalls dispatch indefinitely. No skip to other leaves; run order is strict.
  - Buffer full: pushes still land safely because credits were reserved at accept.
  - Empty buffer: no strobe.
  - Simultaneous push and pop on a full or empty buffer is legal; occupancy stays consistent.
  - Reset mid-operation: pipe tags cleared, so presorter data still in flight is discarded.

Optional Feature:
- Macro PRESORT_CHECK_EN.
- Defined:
  - Adds output sort_err (1 bit, reset 0).
  - Sets sticky if any pushed chunk has element k > element k+1 for some k in 0..14.
  - Cleared only by reset.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package presort_pkg: CHUNK_ELEMS=16 and a chunk width function of DATA_WIDTH; PRESORT_LATENCY_DEFAULT=10; a tagged-entry type {data,last}.
- Sub-module presort_obuf: synchronous circular FIFO (push, pop, head, empty, full), instantiated once.

Test Plan:
- Single beat, elements 15..0 descending, tlast=1, leaves never full -> leaf_wr_en=8'h01 exactly at cycle 11 after accept with ascending 0..15. run_done pulses with the write; cur_leaf becomes 1.
- 32 back-to-back beats, CHUNKS_PER_RUN=4 -> leaves 0..7 each receive 4 chunks in order. cur_leaf wraps to 0; s_tready never drops.
- leaf_full[0] held high for 40 cycles under continuous input -> s_tready falls after 16 accepted beats total. No data loss; all 16 delivered in order after release.
- Stream of 6 beats with tlast on the 6th -> leaf 0 gets 4 chunks, leaf 1 gets 2; run_done pulses twice; the next stream starts at leaf 2.
- aresetn pulsed low 5 cycles after 3 accepts -> no leaf_wr_en asserts from those beats; s_tready=0 during reset and 1 one cycle after release.
- With PRESORT_CHECK_EN, a stub presorter outputs an unsorted chunk -> sort_err=1 and remains 1 until reset.
